// File: rtl/ecg_boxcar_filter_axis.sv
// Moving-average (boxcar) low-pass filter for the ECG channel, AXI4-Stream in/out.
// Keeps a running sum over the last 2**LOG2_TAPS samples and emits its floor average.
module ecg_boxcar_filter_axis #(
    parameter int LOG2_TAPS = 3,
    parameter bit PRIME     = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic signed [15:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready
);

    localparam int N  = 1 << LOG2_TAPS;
    localparam int AW = 16 + LOG2_TAPS;
    localparam logic [LOG2_TAPS-1:0] LAST = LOG2_TAPS'(N - 1);

    logic signed [15:0]   line_q [N];
    logic [LOG2_TAPS-1:0] wptr;
    logic [LOG2_TAPS-1:0] fcnt;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic signed [15:0]   avg_next;
    logic                 accept;
    logic                 emit;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign emit          = accept && (!PRIME || fcnt == LAST);

    // Sum of the window after this sample: add the newest, drop the one it overwrites.
    assign acc_next = acc + AW'(s_axis_tdata) - AW'(line_q[wptr]);
    assign avg_next = 16'(acc_next >>> LOG2_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                line_q[i] <= '0;
            end
            wptr          <= '0;
            fcnt          <= '0;
            acc           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (accept) begin
                line_q[wptr] <= s_axis_tdata;
                acc          <= acc_next;
                wptr         <= wptr + LOG2_TAPS'(1);
                if (fcnt != LAST) begin
                    fcnt <= fcnt + LOG2_TAPS'(1);
                end
            end
            if (emit) begin
                m_axis_tdata  <= avg_next;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ecg_boxcar_filter_axis.md
# ecg_boxcar_filter_axis

AXI4-Stream moving-average (boxcar) low-pass filter that sits directly downstream of the MCP3202 SPI/FIFO stage. It consumes signed 16-bit ADC samples from the FIFO master port and produces one signed 16-bit filtered sample per accepted input. The filter averages the last 2^LOG2_TAPS samples. Its purpose is to suppress high-frequency and mains noise on the ECG channel before further processing.

## Interface
- LOG2_TAPS, 3: window length N = 2^LOG2_TAPS. Legal range is 1–5. The sample delay line is built from registers.
- PRIME, 0: when 1, the first N-1 accepted samples after reset are consumed but produce no output.
- clk  in  1  system clock, 10–200 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  16  signed input sample from the ADC FIFO.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  filter can accept an input sample.
- m_axis_tdata  out  16  signed filtered sample.
- m_axis_tvalid  out  1  filtered sample valid.
- m_axis_tready  in  1  downstream can accept the filtered sample.

## Operation
- Accept event: s_axis_tvalid & s_axis_tready in the same cycle.
- Storage:
  - delay line of N signed 16-bit registers;
  - write pointer wptr of LOG2_TAPS bits, wrapping N-1 → 0;
  - running sum acc, signed, 16+LOG2_TAPS bits;
  - fill counter fcnt, saturating at N-1.
- On each accept:
  - acc ← acc + x_new − line[wptr];
  - line[wptr] ← x_new;
  - wptr ← wptr+1 (mod N);
  - fcnt ← min(fcnt+1, N-1).
- Output value is (acc_next) >>> LOG2_TAPS.
  - Arithmetic shift, so the result is the floor of the average.
  - The result always fits in 16 bits; no saturation logic is required.
- acc width is exact: N full-scale samples (N·32767 or N·(−32768)) never overflow.
- Emission:
  - On accept, the output register loads and m_axis_tvalid sets, unless PRIME=1 and fcnt<N-1 before this accept.
  - While priming, the sample still updates acc, line, wptr and fcnt; m_axis_tvalid is unchanged.
- Handshake:
  - s_axis_tready = !m_axis_tvalid | m_axis_tready. This is combinational, a single-stage output register.
  - On a cycle with m_axis_tvalid & m_axis_tready and no new output loaded, m_axis_tvalid clears.
  - Simultaneous output drain and input accept: the output register reloads and m_axis_tvalid stays 1. Full throughput is one sample per clock.
  - m_axis_tdata and m_axis_tvalid are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Reset (asynchronous, any time including mid-stream):
  - line, acc, wptr and fcnt clear to 0;
  - m_axis_tvalid=0, m_axis_tdata=0;
  - a pending output sample is discarded.
- Until N samples have been accepted, the zeroed delay line produces a ramp-in. PRIME=1 hides the first N-1 outputs of that ramp.

## Timing
- Latency: the sample accepted on the rising edge of cycle k appears on m_axis_tdata with m_axis_tvalid=1 from cycle k+1.
- s_axis_tready after reset is 1, because m_axis_tvalid=0.
- Reset values: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0.
- Backpressure: with m_axis_tready held 0 and an output pending, s_axis_tready=0 and no state changes. Input data is never dropped.
- The ADC sample rate (~500 Hz) is far below the clock rate, so backpressure never builds in normal operation. The block must nonetheless be correct at one sample per clock.

## Test plan
- LOG2_TAPS=2, PRIME=0, m_axis_tready=1; inputs 4, 8, 12, 16, 20 back-to-back → outputs 1, 3, 6, 10, 14, each one cycle after its input.
- LOG2_TAPS=2, PRIME=1; same inputs → exactly two outputs: 10, 14.
- LOG2_TAPS=3; eight inputs of −1, then eight of −32768, then eight of 32767 → −1 outputs are floor values (−1,−1,…,−1). The final output of each run is −1, −32768 and 32767 respectively, with no wrap.
- LOG2_TAPS=2; hold m_axis_tready=0 after the first output while s_axis_tvalid=1 with data 100 → s_axis_tready=0 and m_axis_tdata held for 10 cycles. Release → the next input is accepted in the same cycle; the output sequence matches the unstalled reference model.
- Assert rst_n=0 asynchronously mid-stream with m_axis_tvalid=1 → m_axis_tvalid and m_axis_tdata drop immediately. After release, inputs 4, 4, 4, 4 (LOG2_TAPS=2) → outputs 1, 2, 3, 4, showing the delay line was cleared.
- Randomised tvalid/tready, 10k samples, LOG2_TAPS=1..5 → every output matches the floor-average golden model; no loss or duplication.
